// File: rtl/regfile_dbg.sv
// Parametrised register file with hard-wired R0, optional write-to-read bypass,
// and a handshaked dump engine that streams a register range one beat per cycle.
module regfile_dbg #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic                dump_start,
  input  logic [AW-1:0]       dump_first,
  input  logic [AW:0]         dump_count,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_busy,
  output logic                dump_done
);

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  localparam logic [AW:0] REM_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] regs [NREGS];
  state_t          state, state_n;
  logic [AW:0]     remaining;
  logic [AW-1:0]   next_idx;

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (raddr[i*AW +: AW] == '0)
        rdata[i*XLEN +: XLEN] = '0;
      else if (BYPASS != 0 && we && waddr == raddr[i*AW +: AW])
        rdata[i*XLEN +: XLEN] = wdata;
      else
        rdata[i*XLEN +: XLEN] = regs[raddr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (dump_start) state_n = (dump_count == '0) ? FIN : SEND;
      SEND: if (dump_ready && remaining == REM_ONE) state_n = FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dump_valid = (state == SEND);
    dump_busy  = (state == SEND);
    dump_done  = (state == FIN);
  end

  // Index arithmetic is AW bits wide, so the range wraps mod NREGS for free.
  assign next_idx = dump_idx + 1'b1;

  // Beat data is a snapshot of stored values: it holds across stalls and
  // never sees a same-cycle write.
  always_ff @(posedge clk1) begin
    if (rst) begin
      remaining <= '0;
      dump_idx  <= '0;
      dump_data <= '0;
    end else begin
      case (state)
        IDLE: if (dump_start && dump_count != '0) begin
          remaining <= dump_count;
          dump_idx  <= dump_first;
          dump_data <= regs[dump_first];
        end
        SEND: if (dump_ready) begin
          remaining <= remaining - 1'b1;
          if (remaining != REM_ONE) begin
            dump_idx  <= next_idx;
            dump_data <= regs[next_idx];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dbg.sv
// Directed bench for regfile_dbg: table-driven read/write vectors plus
// hand-written dump sequences (back-to-back, stall, wrap, zero count, reset).
module tb_regfile_dbg;

  logic        clk1 = 1'b0;
  logic        rst, we, dump_start, dump_ready;
  logic [4:0]  waddr, dump_first;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [5:0]  dump_count;
  logic [63:0] rdata, rdata_nb;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        nb_valid, nb_busy, nb_done;
  logic [4:0]  nb_idx;
  logic [31:0] nb_data;

  int nchk = 0;
  int nfail = 0;

  always #5 clk1 = ~clk1;

  regfile_dbg #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1)) dut (
    .clk1(clk1), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata),
    .dump_start(dump_start), .dump_first(dump_first), .dump_count(dump_count),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  regfile_dbg #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0)) dut_nb (
    .clk1(clk1), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_nb),
    .dump_start(dump_start), .dump_first(dump_first), .dump_count(dump_count),
    .dump_valid(nb_valid), .dump_ready(dump_ready), .dump_idx(nb_idx),
    .dump_data(nb_data), .dump_busy(nb_busy), .dump_done(nb_done)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] enb;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic beat(input string nm, input logic [4:0] idx, input logic [31:0] data);
    chk({nm, " valid"}, {31'd0, dump_valid}, 32'd1);
    chk({nm, " idx"},   {27'd0, dump_idx}, {27'd0, idx});
    chk({nm, " data"},  dump_data, data);
    chk({nm, " busy"},  {31'd0, dump_busy}, 32'd1);
  endtask

  task automatic fin(input string nm);
    chk({nm, " fin valid"}, {31'd0, dump_valid}, 32'd0);
    chk({nm, " fin done"},  {31'd0, dump_done}, 32'd1);
    chk({nm, " fin busy"},  {31'd0, dump_busy}, 32'd0);
    tick();
    chk({nm, " idle done"}, {31'd0, dump_done}, 32'd0);
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic start(input logic [4:0] first, input logic [5:0] count);
    dump_start = 1'b1; dump_first = first; dump_count = count;
    tick();
    dump_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd1, 32'd10,     5'd1, 5'd0, 32'd10, 32'd0,  32'd0};
    vecs[1] = '{1'b1, 5'd2, 32'd20,     5'd1, 5'd2, 32'd10, 32'd20, 32'd10};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFF,   5'd0, 5'd0, 32'd0,  32'd0,  32'd0};
    vecs[3] = '{1'b0, 5'd0, 32'd0,      5'd1, 5'd2, 32'd10, 32'd20, 32'd10};
    vecs[4] = '{1'b0, 5'd0, 32'd0,      5'd0, 5'd0, 32'd0,  32'd0,  32'd0};
    vecs[5] = '{1'b1, 5'd4, 32'd30,     5'd4, 5'd4, 32'd30, 32'd30, 32'd0};
    vecs[6] = '{1'b0, 5'd0, 32'd0,      5'd4, 5'd3, 32'd30, 32'd0,  32'd30};

    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h55;
    raddr = '0; dump_start = 1'b0; dump_first = '0; dump_count = '0; dump_ready = 1'b0;
    tick();
    tick();
    chk("rst valid", {31'd0, dump_valid}, 32'd0);
    chk("rst busy",  {31'd0, dump_busy}, 32'd0);
    chk("rst done",  {31'd0, dump_done}, 32'd0);
    chk("rst idx",   {27'd0, dump_idx}, 32'd0);
    chk("rst data",  dump_data, 32'd0);
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      chk("rst rd0", rdata[31:0], 32'd0);
      chk("rst rd1", rdata[63:32], 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      we = vecs[i].we; waddr = vecs[i].wa; wdata = vecs[i].wd;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      chk("vec rd0", rdata[31:0], vecs[i].e0);
      chk("vec rd1", rdata[63:32], vecs[i].e1);
      chk("vec nobypass rd0", rdata_nb[31:0], vecs[i].enb);
      tick();
    end
    we = 1'b0;

    for (int r = 1; r <= 5; r++) write(5'(r), 32'(r));
    write(5'd30, 32'h300);
    write(5'd31, 32'h310);

    // back-to-back dump
    dump_ready = 1'b1;
    start(5'd1, 6'd5);
    for (int k = 0; k < 5; k++) begin
      beat("b2b", 5'(k + 1), 32'(k + 1));
      tick();
    end
    fin("b2b");

    // stall with write to the stalled register
    dump_ready = 1'b0;
    start(5'd2, 6'd3);
    for (int k = 0; k < 4; k++) begin
      we = (k == 0); waddr = 5'd2; wdata = 32'd99;
      beat("stall", 5'd2, 32'd2);
      tick();
    end
    we = 1'b0;
    dump_ready = 1'b1;
    beat("stall rel0", 5'd2, 32'd2);
    tick();
    beat("stall rel1", 5'd3, 32'd3);
    tick();
    beat("stall rel2", 5'd4, 32'd4);
    tick();
    fin("stall");
    start(5'd2, 6'd1);
    beat("redump", 5'd2, 32'd99);
    tick();
    fin("redump");

    // wrap-around with an ignored start mid-dump
    start(5'd30, 6'd4);
    beat("wrap0", 5'd30, 32'h300);
    dump_start = 1'b1; dump_first = 5'd5; dump_count = 6'd1;
    tick();
    dump_start = 1'b0;
    beat("wrap1", 5'd31, 32'h310);
    tick();
    beat("wrap2", 5'd0, 32'd0);
    tick();
    beat("wrap3", 5'd1, 32'd1);
    tick();
    fin("wrap");

    // zero-count dump
    start(5'd3, 6'd0);
    fin("zero");

    // reset mid-dump, then a fresh dump
    start(5'd1, 6'd5);
    beat("rmid0", 5'd1, 32'd1);
    tick();
    beat("rmid1", 5'd2, 32'd99);
    tick();
    beat("rmid2", 5'd3, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid valid", {31'd0, dump_valid}, 32'd0);
    chk("rmid busy",  {31'd0, dump_busy}, 32'd0);
    chk("rmid done",  {31'd0, dump_done}, 32'd0);
    write(5'd1, 32'd7);
    start(5'd1, 6'd2);
    beat("post0", 5'd1, 32'd7);
    tick();
    beat("post1", 5'd2, 32'd0);
    tick();
    fin("post");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_dbg.md
Name: regfile_dbg

Overview:
- Parametrised, single-clock register file for the next-generation pipelined RISC core; replaces the bare RegFile array.
- Adds a configurable number of read ports, optional write-to-read bypass, a hard-wired zero register, and a synchronous reset that clears every register.
- Adds a handshaked debug dump engine that streams a register range out of the file, one register per beat. Benches and a debug UART use it instead of reaching into internal state.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; must be a power of two and at least 2.
- AW, 5, address width; must equal log2(NREGS).
- NRD, 2, number of combinational read ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored values only.

Ports:
- clk1  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- dump_start  in  1  one-cycle request to start a dump.
- dump_first  in  AW  first register index of the dump.
- dump_count  in  AW+1  number of registers to dump, 0..NREGS.
- dump_valid  out  1  a dump beat is presented.
- dump_ready  in  1  consumer accepts the beat.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  XLEN  register value of the current beat.
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset: all registers, dump_valid, dump_busy, dump_done, dump_idx and dump_data go to 0. The FSM returns to IDLE, including when reset is asserted mid-dump.
- Write: on the clock edge, if we=1 and waddr!=0, reg[waddr] <= wdata. Writes to R0 are discarded.
- Read (combinational, zero latency), per port:
  - raddr==0 returns 0.
  - Otherwise, if BYPASS=1 and we=1 and waddr==raddr, return wdata.
  - Otherwise return reg[raddr].
  - All ports are independent and may address the same register.
- Dump FSM states: IDLE, SEND, FIN.
- IDLE, on dump_start:
  - count==0: go to FIN with no beats.
  - Otherwise latch remaining=count, set dump_idx=first, snapshot dump_data=reg[first] (stored value; same-cycle write not bypassed), set dump_valid=1 and dump_busy=1, and go to SEND.
  - Timing: start sampled at edge N, so the first beat is visible in the cycle after edge N.
- SEND, on an edge where dump_valid=1 and dump_ready=1, decrement remaining:
  - If remaining becomes 0: dump_valid=0 and go to FIN.
  - Otherwise dump_idx = (dump_idx+1) mod NREGS, snapshot the next register, and keep valid high. This gives back-to-back beats, one per cycle, when ready is held high.
- SEND stall (valid=1, ready=0): dump_idx and dump_data hold. A write to the stalled register does not change dump_data; later beats see the written value.
- FIN: dump_done=1 and dump_busy=0 for exactly one cycle, then IDLE.
- dump_start while busy or in FIN is ignored.
- Index wrap-around: the range wraps mod NREGS, e.g. first=30, count=4 yields indices 30, 31, 0, 1. Beat index 0 always carries data 0.
- Normal reads and writes are fully functional during a dump; no port stalls the other.

Test Plan:
- Reset then read: assert rst for 2 cycles with we=1, waddr=5, wdata=0x55; read all addresses -> rdata=0 on every port, reg5 still 0 after reset.
- Write/read, R0, bypass:
  - write R1=10, R2=20, then R0=0xFFFF -> R1=10, R2=20, R0=0 on both ports.
  - Same cycle: we=1, waddr=4, wdata=30, raddr0=4 -> rdata0=30 with BYPASS=1; rdata0=previous value (0) with BYPASS=0.
- Back-to-back dump: R1..R5 = 1..5; dump_start first=1 count=5 with ready=1 -> valid for 5 consecutive cycles, idx 1..5, data 1..5; done pulses 1 cycle later, busy low.
- Backpressure and snapshot:
  - dump first=2 count=3; ready=0 for 4 cycles on the first beat while writing R2=99 -> beat 0 stays idx2 with the old value.
  - Then release ready -> beats idx3, idx4; a re-dump of R2 returns 99.
- Wrap and zero count:
  - first=30 count=4 -> idx 30, 31, 0, 1, with idx0 data 0.
  - count=0 -> no valid; done pulses on the cycle after start.
  - dump_start during busy -> ignored; beat sequence unchanged.
- Reset mid-dump: assert rst while on beat 2 of 5 -> next cycle valid=0, busy=0, done=0; a new dump_start then runs normally.
